// File: rtl/cnn_act_pkg.sv
// Shared constants, FSM state type and the ReLU-clip used by the activation scheduler.
package cnn_act_pkg;

    localparam int ACT_MAX        = 127;
    localparam int ACT_MIN        = 0;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic {IDLE, BUSY} state_t;

    // Full-width signed compare so large accumulators saturate instead of wrapping.
    function automatic logic [7:0] act_clip(input logic signed [31:0] x);
        logic [7:0] r;
        if (x > ACT_MAX)
            r = 8'(ACT_MAX);
        else if (x < ACT_MIN)
            r = 8'(ACT_MIN);
        else
            r = x[7:0];
        return r;
    endfunction

endpackage

// File: rtl/cnn_rr_arb.sv
// Combinational round-robin selector: first requester at or after ptr, wrapping.
module cnn_rr_arb #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic               found
);

    int best_d;
    int d;

    // Distance from ptr decides priority; the nearest requester wins.
    always_comb begin
        best_d = NUM_REQ;
        d      = 0;
        gnt    = '0;
        found  = |req;
        for (int i = 0; i < NUM_REQ; i++) begin
            d = (i - int'(ptr) + NUM_REQ) % NUM_REQ;
            if (req[i] && d < best_d)
                best_d = d;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            d = (i - int'(ptr) + NUM_REQ) % NUM_REQ;
            gnt[i] = req[i] && (d == best_d);
        end
    end

endmodule

// File: rtl/cnn_act_sched.sv
// Shares one ReLU-clip datapath between NUM_REQ accumulator lanes and packs 4 bytes per word.
// Optional feature: CNN_ACT_SCHED_SHIFT_EN adds cfg_shift requantization before the clip.
module cnn_act_sched
    import cnn_act_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*32-1:0] req_data,
    input  logic [NUM_REQ-1:0]    req_last,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  out_valid,
    output logic [31:0]           out_data,
    output logic [3:0]            out_be,
    output logic                  out_last,
    output logic [ID_W-1:0]       out_id,
    input  logic                  out_ready
`ifdef CNN_ACT_SCHED_SHIFT_EN
    ,
    input  logic [4:0]            cfg_shift
`endif
);

    state_t                      state, state_nx;
    logic [ID_W-1:0]             grant, rr_ptr, gnt_id;
    logic [NUM_REQ-1:0]          gnt_oh;
    logic                        found;
    logic [1:0]                  cnt;
    logic [BYTES_PER_WORD-1:0][7:0] pack_p0;
    logic [BYTES_PER_WORD-1:0][7:0] word;
    logic [3:0]                  be;
    logic signed [31:0]          cur_data, acc_sh;
    logic                        cur_valid, cur_last;
    logic                        out_free, beat, load;
    logic [7:0]                  act;

    cnn_rr_arb #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .gnt   (gnt_oh),
        .found (found)
    );

    always_comb begin
        gnt_id    = '0;
        cur_data  = '0;
        cur_valid = 1'b0;
        cur_last  = 1'b0;
        req_ready = '0;
        out_free  = !out_valid || out_ready;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_oh[i])
                gnt_id = ID_W'(i);
            if (grant == ID_W'(i)) begin
                cur_data  = req_data[32*i +: 32];
                cur_valid = req_valid[i];
                cur_last  = req_last[i];
            end
            req_ready[i] = (state == BUSY) && (grant == ID_W'(i)) && out_free;
        end
    end

`ifdef CNN_ACT_SCHED_SHIFT_EN
    logic [4:0] shift_q;
    always_ff @(posedge clk)
        if (state == IDLE && found)
            shift_q <= cfg_shift;
    assign acc_sh = cur_data >>> shift_q;
`else
    assign acc_sh = cur_data;
`endif

    assign act  = act_clip(acc_sh);
    assign beat = (state == BUSY) && cur_valid && out_free;
    assign load = beat && (cnt == 2'd3 || cur_last);

    // Bytes below cnt come from the pack register, the new byte lands at cnt, the rest are zero.
    always_comb begin
        word = '0;
        be   = '0;
        for (int b = 0; b < BYTES_PER_WORD; b++) begin
            if (2'(b) < cnt)
                word[b] = pack_p0[b];
            else if (2'(b) == cnt)
                word[b] = act;
            be[b] = (2'(b) <= cnt);
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (found)            state_nx = BUSY;
            BUSY:    if (beat && cur_last) state_nx = IDLE;
            default:                       state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Stage p0: partial-word pack register; stale bytes are masked by cnt.
    always_ff @(posedge clk)
        if (beat && !load)
            pack_p0[cnt] <= act;

    // Stage p1: output word register and burst control.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant     <= '0;
            rr_ptr    <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_be    <= '0;
            out_last  <= 1'b0;
            out_id    <= '0;
        end else begin
            if (state == IDLE && found)
                grant <= gnt_id;
            if (beat) begin
                cnt <= load ? 2'd0 : cnt + 2'd1;
                if (cur_last)
                    rr_ptr <= (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
            end
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= word;
                out_be    <= be;
                out_last  <= cur_last;
                out_id    <= grant;
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_data  <= '0;
                out_be    <= '0;
                out_last  <= 1'b0;
                out_id    <= '0;
            end
        end
    end

endmodule
